// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Optional build macro: HAZARD_PERF_CNT_EN (stall/flush performance counters).
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int MC_LAT_W_DEF = 4;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_hold;
    logic hold_ifid;
    logic clear_ifid;
    logic hold_idex;
    logic clear_idex;
    logic hold_exmem;
    logic clear_exmem;
    logic hold_memwb;
    logic clear_memwb;
  } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: stage hazard inputs and stage-register hold/clear outputs.
// Optional build macro: HAZARD_PERF_CNT_EN adds the performance counter signals.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW   = 5,
  parameter int MC_LAT_W = 4
);
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic                id_uses_rt;
  logic                ex_memread;
  logic [REG_AW-1:0]   ex_rt;
  logic                mem_branch_taken;
  logic                ex_mc_start;
  logic [MC_LAT_W-1:0] ex_mc_lat;
  logic                dmem_wait;

  logic pc_hold;
  logic hold_ifid, clear_ifid;
  logic hold_idex, clear_idex;
  logic hold_exmem, clear_exmem;
  logic hold_memwb, clear_memwb;
  logic mc_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken,
           ex_mc_start, ex_mc_lat, dmem_wait,
`ifdef HAZARD_PERF_CNT_EN
    input  perf_stall_cycles, perf_flushes,
`endif
    input  pc_hold, hold_ifid, clear_ifid, hold_idex, clear_idex,
           hold_exmem, clear_exmem, hold_memwb, clear_memwb, mc_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken,
           ex_mc_start, ex_mc_lat, dmem_wait,
`ifdef HAZARD_PERF_CNT_EN
    output perf_stall_cycles, perf_flushes,
`endif
    output pc_hold, hold_ifid, clear_ifid, hold_idex, clear_idex,
           hold_exmem, clear_exmem, hold_memwb, clear_memwb, mc_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mc_stall_counter.sv
// Down-counter of remaining multicycle busy cycles: load, decrement, freeze (no op) or abort.
// done_o flags the final busy cycle.
module mc_stall_counter #(
  parameter int MC_LAT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [MC_LAT_W-1:0] load_val_i,
  input  logic                dec_i,
  input  logic                abort_i,
  output logic [MC_LAT_W-1:0] cnt_o,
  output logic                done_o
);

  logic [MC_LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (abort_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - MC_LAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == MC_LAT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: load-use stall, branch flush, multicycle EX stall, dmem wait.
// Optional build macro: HAZARD_PERF_CNT_EN adds perf_stall_cycles / perf_flushes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MC_LAT_W = MC_LAT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_hazard_ctrl_if.slave    bus
);

  logic [0:0]          state_q, state_d;
  logic [MC_LAT_W-1:0] mc_cnt;
  logic                mc_done;
  logic                busy, mc_go, lat_ge3, load_use;
  logic                cnt_load, cnt_dec, cnt_abort;
  hz_ctrl_t            ctrl;

  assign busy    = (state_q == ST_MC_BUSY);
  assign lat_ge3 = (bus.ex_mc_lat >= MC_LAT_W'(3));
  assign mc_go   = !busy && bus.ex_mc_start && (bus.ex_mc_lat >= MC_LAT_W'(2));

  assign load_use = bus.ex_memread && (bus.ex_rt != REG_AW'(REG_ZERO)) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && bus.ex_rt == bus.id_rt));

  assign cnt_abort = !bus.dmem_wait && bus.mem_branch_taken;
  assign cnt_load  = !bus.dmem_wait && !bus.mem_branch_taken && mc_go;
  assign cnt_dec   = !bus.dmem_wait && !bus.mem_branch_taken && busy;

  // The counter holds busy cycles still to come after the start cycle, so a
  // lat-cycle op stalls for lat-1 cycles in total.
  mc_stall_counter #(.MC_LAT_W(MC_LAT_W)) u_mc_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (bus.ex_mc_lat - MC_LAT_W'(2)),
    .dec_i      (cnt_dec),
    .abort_i    (cnt_abort),
    .cnt_o      (mc_cnt),
    .done_o     (mc_done)
  );

  always_comb begin
    state_d = state_q;
    if (!bus.dmem_wait) begin
      if (bus.mem_branch_taken)
        state_d = ST_RUN;
      else if (busy && mc_done)
        state_d = ST_RUN;
      else if (mc_go && lat_ge3)
        state_d = ST_MC_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    ctrl = '0;
    if (!rst_n) begin
      ctrl.pc_hold     = 1'b1;
      ctrl.clear_ifid  = 1'b1;
      ctrl.clear_idex  = 1'b1;
      ctrl.clear_exmem = 1'b1;
      ctrl.clear_memwb = 1'b1;
    end else if (bus.dmem_wait) begin
      ctrl.pc_hold    = 1'b1;
      ctrl.hold_ifid  = 1'b1;
      ctrl.hold_idex  = 1'b1;
      ctrl.hold_exmem = 1'b1;
      ctrl.hold_memwb = 1'b1;
    end else if (bus.mem_branch_taken) begin
      ctrl.clear_ifid  = 1'b1;
      ctrl.clear_idex  = 1'b1;
      ctrl.clear_exmem = 1'b1;
    end else if (busy || mc_go) begin
      // EX op keeps its slot; a bubble enters EX/MEM while it iterates.
      ctrl.pc_hold     = 1'b1;
      ctrl.hold_ifid   = 1'b1;
      ctrl.hold_idex   = 1'b1;
      ctrl.clear_exmem = 1'b1;
    end else if (load_use) begin
      ctrl.pc_hold    = 1'b1;
      ctrl.hold_ifid  = 1'b1;
      ctrl.clear_idex = 1'b1;
    end
  end

  assign bus.pc_hold     = ctrl.pc_hold;
  assign bus.hold_ifid   = ctrl.hold_ifid;
  assign bus.clear_ifid  = ctrl.clear_ifid;
  assign bus.hold_idex   = ctrl.hold_idex;
  assign bus.clear_idex  = ctrl.clear_idex;
  assign bus.hold_exmem  = ctrl.hold_exmem;
  assign bus.clear_exmem = ctrl.clear_exmem;
  assign bus.hold_memwb  = ctrl.hold_memwb;
  assign bus.clear_memwb = ctrl.clear_memwb;
  assign bus.mc_busy     = busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctrl.pc_hold)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.mem_branch_taken && !bus.dmem_wait)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = stall_cnt_q;
  assign bus.perf_flushes      = flush_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^mc_cnt;
`endif

endmodule
